// File: rtl/sti_pkg.sv
// Shared encodings, FSM states and helpers for the sti_serializer block.
package sti_pkg;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FILL,
        DONE
    } sti_state_e;

    // Frame length in bits: (code + 1) bytes.
    function automatic logic [5:0] length_bits(input logic [1:0] len);
        logic [2:0] n_bytes;
        n_bytes = {1'b0, len} + 3'd1;
        return {n_bytes, 3'b000};
    endfunction

endpackage

// File: rtl/sti_serializer_if.sv
// Host-side parallel load and serial output bundle of sti_serializer.
// Optional drop_cnt signal present when STI_DROP_CNT_EN is defined.
interface sti_serializer_if;

    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        ready;
    logic        so_data;
    logic        so_valid;
    logic        final_valid;
    logic        done;
`ifdef STI_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    modport master (
        output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        input  ready, so_data, so_valid, final_valid, done
`ifdef STI_DROP_CNT_EN
        , input drop_cnt
`endif
    );

    modport slave (
        input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        output ready, so_data, so_valid, final_valid, done
`ifdef STI_DROP_CNT_EN
        , output drop_cnt
`endif
    );

endinterface

// File: rtl/sti_frame_build.sv
// Builds the 32-bit shift frame from the 16-bit host word; the first bit to
// send always sits in frame[31], whatever the length and bit order.
module sti_frame_build
    import sti_pkg::*;
(
    input  logic [15:0] pi_data,
    input  logic [1:0]  pi_length,
    input  logic        pi_fill,
    input  logic        pi_msb,
    input  logic        pi_low,
    output logic [31:0] frame,
    output logic [5:0]  count
);

    logic [31:0] payload;
    logic [31:0] reversed;

    // Payload is right-aligned: its N bits sit in payload[N-1:0].
    always_comb begin
        payload = '0;
        unique case (pi_length)
            LEN_8:  payload = {24'h0, (pi_low ? pi_data[15:8] : pi_data[7:0])};
            LEN_16: payload = {16'h0, pi_data};
            LEN_24: payload = pi_fill ? {8'h0, pi_data, 8'h0} : {16'h0, pi_data};
            LEN_32: payload = pi_fill ? {pi_data, 16'h0} : {16'h0, pi_data};
            default: payload = '0;
        endcase
    end

    always_comb begin
        reversed = '0;
        for (int i = 0; i < 32; i++) begin
            reversed[i] = payload[31-i];
        end
    end

    always_comb begin
        count = length_bits(pi_length);
        // MSB-first left-aligns the payload; LSB-first bit-reversal puts bit 0 on top.
        frame = pi_msb ? (payload << (6'd32 - count)) : reversed;
    end

endmodule

// File: rtl/sti_serializer.sv
// Serial transmitter: shifts 8/16/24/32-bit frames out one bit per cycle and pads
// with final_valid zero bits up to TOTAL_BITS. Optional STI_DROP_CNT_EN adds drop_cnt.
module sti_serializer
    import sti_pkg::*;
#(
    parameter int unsigned TOTAL_BITS = 2048,
    parameter int unsigned CNT_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    sti_serializer_if.slave   bus
);

    localparam logic [CNT_W-1:0] TotalCnt = CNT_W'(TOTAL_BITS);

    sti_state_e       state_q;
    logic [31:0]      shreg_q;
    logic [5:0]       bits_left_q;
    logic [CNT_W-1:0] sent_q;
    logic [CNT_W-1:0] pad_left_q;
    logic             ready_q;
    logic             so_data_q;
    logic             so_valid_q;
    logic             final_valid_q;
    logic             done_q;

    logic [31:0]      frame;
    logic [5:0]       count;

    sti_frame_build u_frame_build (
        .pi_data   (bus.pi_data),
        .pi_length (bus.pi_length),
        .pi_fill   (bus.pi_fill),
        .pi_msb    (bus.pi_msb),
        .pi_low    (bus.pi_low),
        .frame     (frame),
        .count     (count)
    );

    // sent_q counts bits as they are issued, so it is current once back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bits_left_q   <= '0;
            sent_q        <= '0;
            pad_left_q    <= '0;
            ready_q       <= 1'b1;
            so_data_q     <= 1'b0;
            so_valid_q    <= 1'b0;
            final_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        shreg_q     <= {frame[30:0], 1'b0};
                        so_data_q   <= frame[31];
                        so_valid_q  <= 1'b1;
                        ready_q     <= 1'b0;
                        bits_left_q <= count - 6'd1;
                        if (sent_q != TotalCnt) begin
                            sent_q <= sent_q + CNT_W'(1);
                        end
                        state_q     <= SHIFT;
                    end else if (bus.pi_end) begin
                        ready_q <= 1'b0;
                        if (sent_q < TotalCnt) begin
                            final_valid_q <= 1'b1;
                            pad_left_q    <= TotalCnt - sent_q - CNT_W'(1);
                            state_q       <= FILL;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (bits_left_q == 6'd0) begin
                        so_valid_q <= 1'b0;
                        so_data_q  <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        so_data_q   <= shreg_q[31];
                        shreg_q     <= {shreg_q[30:0], 1'b0};
                        bits_left_q <= bits_left_q - 6'd1;
                        if (sent_q != TotalCnt) begin
                            sent_q <= sent_q + CNT_W'(1);
                        end
                    end
                end
                FILL: begin
                    if (pad_left_q == '0) begin
                        final_valid_q <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        pad_left_q <= pad_left_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.so_data     = so_data_q;
    assign bus.so_valid    = so_valid_q;
    assign bus.final_valid = final_valid_q;
    assign bus.done        = done_q;

`ifdef STI_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    logic       drop_event;

    // ready_q is high only in IDLE, where a simultaneous pi_end loses to load.
    assign drop_event = (!ready_q && (bus.load || bus.pi_end)) ||
                        (ready_q && bus.load && bus.pi_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_event && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule
